adc_sample_fifo: RTL and testbench
==================================

Name: adc_sample_fifo

Overview:
Buffers decimated sigma-delta ADC samples downstream of the ADC/CIC output stage. The ADC raises its valid flag for one cycle per decimated sample and cannot be stalled. This block absorbs that pulse stream into a small synchronous FIFO and presents the samples on a valid/ready interface to slower consumers (UART/SPI readout, DSP). Dropped samples are flagged and counted.

Parameters:
DATA_WIDTH, 16, sample width; matches ADC output width.
DEPTH, 16, number of FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous, active-high reset.
in_data  input  DATA_WIDTH  sample from ADC (unsigned, offset binary).
in_valid  input  1  one-cycle strobe per sample; no backpressure possible.
out_data  output  DATA_WIDTH  head-of-FIFO sample (first-word-fall-through).
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts out_data this cycle.
level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
overflow  output  1  sticky: at least one sample dropped.
overflow_clr  input  1  clears overflow and drop_count.
drop_count  output  16  dropped-sample count, saturates at 0xFFFF.

Behaviour:
- Reset is synchronous and active-high. On the cycle after rst is sampled high:
  - pointers = 0, level = 0, out_valid = 0, overflow = 0, drop_count = 0.
  - Storage is cleared to 0, so out_data = 0.
  - Reset mid-operation discards all contents. Any in_valid or handshake in the rst cycle is ignored.
- Push: when in_valid=1 and not full, in_data is written at wr_ptr and wr_ptr increments.
- Pop: when out_valid=1 and out_ready=1, rd_ptr increments. out_ready while empty has no effect.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level = writes − reads.
- out_valid = (level != 0). out_data = mem[rd_ptr], combinational from storage.
- Latency: a sample pushed at clock edge N is visible with out_valid=1 in the cycle after edge N. There is no empty-bypass: push into an empty FIFO gives out_valid=0 in the push cycle.
- Simultaneous push and pop, not full: level unchanged.
- Full and in_valid with a pop in the same cycle: the push is accepted, level stays DEPTH, no drop.
- Full and in_valid with no pop: the sample is discarded, FIFO contents are unchanged, overflow is set to 1, and drop_count increments (saturating).
- overflow_clr alone: overflow = 0 and drop_count = 0 next cycle.
- overflow_clr and a drop in the same cycle: overflow = 1 and drop_count = 1 (clear then count).
- Data order is strictly preserved across wrap-around.

Optional Feature:
Macro: ADC_FIFO_SIGNED_EN
- Defined: the MSB of in_data is inverted at write, converting offset binary to two's complement. Mid-scale 0x8000 becomes 0x0000, 0x0000 becomes 0x8000, 0xFFFF becomes 0x7FFF. Applies to stored data only; level, flags and timing are identical.
- Undefined: data is stored and output unchanged.

Decomposition:
- Package adc_stream_pkg:
  - DEFAULT_DATA_WIDTH = 16.
  - DROP_CNT_WIDTH = 16.
  - typedef sample_t (bit vector of DEFAULT_DATA_WIDTH).
  - function offset_to_twos(sample_t) returning sample_t.
- One sub-module, fifo_ptr_ctrl:
  - owns wr_ptr, rd_ptr and level;
  - derives full/empty;
  - produces the push_en, pop_en and drop qualifiers.
- Top level holds the storage array, flag and counter logic, and the optional conversion.

Test Plan:
1. Reset; push 0x1234 with out_ready=0 -> next cycle out_valid=1, out_data=0x1234, level=1. Then out_ready=1 for one cycle -> out_valid=0, level=0.
2. Push 0x0000..0x000F (DEPTH=16) with out_ready=0 -> level=16. Push 0xAAAA -> overflow=1, drop_count=1, contents unchanged. Drain -> 0x0000..0x000F in order, 0xAAAA never appears.
3. FIFO full; in_valid=1 with out_ready=1 in the same cycle -> level stays 16, overflow=0, and the new sample emerges last after draining.
4. Full FIFO; drop concurrent with overflow_clr -> overflow=1, drop_count=1. overflow_clr alone next cycle -> overflow=0, drop_count=0. Then force 70000 drops -> drop_count=0xFFFF.
5. Stream 40 samples with out_ready toggling every cycle -> all 40 received in order across pointer wrap, no overflow. Mid-stream at level=5, pulse rst -> next cycle level=0, out_valid=0, out_data=0.
6. With ADC_FIFO_SIGNED_EN: inputs 0x0000, 0x8000, 0xFFFF -> outputs 0x8000, 0x0000, 0x7FFF. Without the macro -> outputs equal inputs.

Source files
------------

// File: rtl/adc_stream_pkg.sv
// adc_stream_pkg: shared definitions for the ADC sample stream path.
//   DEFAULT_DATA_WIDTH : native ADC sample width
//   DROP_CNT_WIDTH     : width of the dropped-sample counter
//   sample_t           : one ADC sample at the default width
//   offset_to_twos()   : offset-binary to two's-complement conversion
package adc_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DROP_CNT_WIDTH     = 16;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] sample_t;

    // Offset binary and two's complement differ only in the sign bit.
    function automatic sample_t offset_to_twos(sample_t s);
        return {~s[DEFAULT_DATA_WIDTH-1], s[DEFAULT_DATA_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer and occupancy control for adc_sample_fifo.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid          : producer strobe (cannot be stalled)
//   out_ready         : consumer accept
//   wr_ptr, rd_ptr    : storage addresses, wrap modulo DEPTH
//   level             : entry count 0..DEPTH
//   empty             : level == 0
//   push_en, pop_en   : qualified write / read this cycle
//   drop              : sample arrives while full with no pop
module fifo_ptr_ctrl
    import adc_stream_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     push_en,
    output logic                     pop_en,
    output logic                     drop
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic full;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_en  = out_ready && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_en = in_valid && (!full || pop_en);
    assign drop    = in_valid && full && !pop_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: absorbs the non-stallable ADC sample strobe into a small
// first-word-fall-through FIFO with a valid/ready read side.
// Build option: ADC_FIFO_SIGNED_EN inverts the sample MSB on write
// (offset binary -> two's complement); default stores samples unchanged.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_data, in_valid      : ADC sample and one-cycle strobe
//   out_data, out_valid    : head sample, FIFO non-empty
//   out_ready              : consumer accepts head this cycle
//   level                  : entry count 0..DEPTH
//   overflow, drop_count   : sticky drop flag and saturating drop count
//   overflow_clr           : clears overflow and drop_count
module adc_sample_fifo
    import adc_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wr_data;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  empty, push_en, pop_en, drop;

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .level     (level),
        .empty     (empty),
        .push_en   (push_en),
        .pop_en    (pop_en),
        .drop      (drop)
    );

`ifdef ADC_FIFO_SIGNED_EN
    assign wr_data = {~in_data[DATA_WIDTH-1], in_data[DATA_WIDTH-2:0]};
`else
    assign wr_data = in_data;
`endif

    // Storage is cleared on reset so out_data reads 0 while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign out_data  = mem[rd_ptr];
    assign out_valid = !empty;

    // Clear takes effect first, so a drop in the clear cycle counts as 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (overflow_clr) begin
            overflow   <= drop;
            drop_count <= drop ? DROP_CNT_WIDTH'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_sample_fifo.sv
module tb_adc_sample_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  level;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_d;

    always #5 clk = ~clk;

    adc_sample_fifo #(.DATA_WIDTH(16), .DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_count   (drop_count)
    );

    // Expected stored value for a raw ADC sample.
    function automatic logic [15:0] model(input logic [15:0] d);
`ifdef ADC_FIFO_SIGNED_EN
        return d ^ 16'h8000;
`else
        return d;
`endif
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        sb.delete();
    endtask

    task automatic fill(input int n, input logic [15:0] base);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = base + 16'(i); in_valid = 1'b1;
            sb.push_back(model(in_data));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_data = 16'hFFFF; out_ready = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sb.delete();
        n_checks++;
        if (level !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 ||
            drop_count !== 16'd0 || out_data !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: lvl=%0d ov=%b of=%b dc=%h od=%h, want all 0",
                     level, out_valid, overflow, drop_count, out_data);
        end
    endtask

    task automatic test_basic();
        in_data = 16'h1234; in_valid = 1'b1; out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL no_bypass: out_valid=%b want 0", out_valid);
        end
        sb.push_back(model(16'h1234));
        tick(); in_valid = 1'b0;
        exp_d = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_d || level !== 5'd1) begin
            n_fail++;
            $display("FAIL basic_push: ov=%b od=%h lvl=%0d want 1 %h 1", out_valid, out_data, level, exp_d);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            n_fail++; $display("FAIL basic_pop: ov=%b lvl=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fill(16, 16'h0000);
        n_checks++;
        if (level !== 5'd16) begin
            n_fail++; $display("FAIL ovf_full_level: got %0d want 16", level);
        end
        in_data = 16'hAAAA; in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || drop_count !== 16'd1 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_drop: of=%b dc=%0d lvl=%0d want 1 1 16", overflow, drop_count, level);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            if (out_valid) begin
                exp_d = sb.pop_front();
                n_checks++;
                if (out_data !== exp_d) begin
                    n_fail++; $display("FAIL ovf_drain: got %h want %h", out_data, exp_d);
                end
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drain_end: left=%0d ov=%b want 0 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        fill(16, 16'h0100);
        in_data = 16'hBEEF; in_valid = 1'b1; out_ready = 1'b1;
        exp_d = sb.pop_front();
        n_checks++;
        if (out_data !== exp_d) begin
            n_fail++; $display("FAIL fpp_head: got %h want %h", out_data, exp_d);
        end
        tick(); in_valid = 1'b0; out_ready = 1'b0;
        sb.push_back(model(16'hBEEF));
        n_checks++;
        if (level !== 5'd16 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_fail++;
            $display("FAIL fpp_level: lvl=%0d of=%b dc=%0d want 16 0 0", level, overflow, drop_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            if (out_valid) begin
                exp_d = sb.pop_front();
                n_checks++;
                if (out_data !== exp_d) begin
                    n_fail++; $display("FAIL fpp_drain: got %h want %h", out_data, exp_d);
                end
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL fpp_drain_end: left=%0d want 0", sb.size());
        end
    endtask

    task automatic test_clear_saturate();
        do_reset();
        fill(16, 16'h0200);
        in_data = 16'h5555; in_valid = 1'b1; overflow_clr = 1'b1; tick();
        n_checks++;
        if (overflow !== 1'b1 || drop_count !== 16'd1) begin
            n_fail++; $display("FAIL clr_with_drop: of=%b dc=%0d want 1 1", overflow, drop_count);
        end
        in_valid = 1'b0; tick(); overflow_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_fail++; $display("FAIL clr_alone: of=%b dc=%0d want 0 0", overflow, drop_count);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        n_checks++;
        if (drop_count !== 16'd100) begin
            n_fail++; $display("FAIL drop_count_100: got %0d want 100", drop_count);
        end
        for (int i = 100; i < 70000; i++) tick();
        in_valid = 1'b0;
        n_checks++;
        if (drop_count !== 16'hFFFF || overflow !== 1'b1 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL drop_sat: dc=%h of=%b lvl=%0d want ffff 1 16", drop_count, overflow, level);
        end
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    endtask

    task automatic test_stream_wrap();
        int sent, got;
        do_reset();
        sent = 0; got = 0;
        for (int i = 0; i < 400 && got < 40; i++) begin
            in_valid  = (i % 2 == 0) && (sent < 40);
            in_data   = 16'h3000 + 16'(sent);
            out_ready = (i % 2 == 1);
            if (in_valid) begin
                sb.push_back(model(in_data));
                sent++;
            end
            if (out_valid && out_ready) begin
                exp_d = sb.pop_front();
                got++;
                n_checks++;
                if (out_data !== exp_d) begin
                    n_fail++; $display("FAIL stream_data: got %h want %h", out_data, exp_d);
                end
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (got != 40 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL stream_end: got=%0d of=%b want 40 0", got, overflow);
        end
        fill(5, 16'h4000);
        n_checks++;
        if (level !== 5'd5) begin
            n_fail++; $display("FAIL pre_rst_level: got %0d want 5", level);
        end
        in_valid = 1'b1; out_ready = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sb.delete();
        n_checks++;
        if (level !== 5'd0 || out_valid !== 1'b0 || out_data !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_rst: lvl=%0d ov=%b od=%h want 0 0 0", level, out_valid, out_data);
        end
    endtask

    task automatic test_signed();
        logic [15:0] ins [3];
        logic [15:0] outs [3];
        ins[0] = 16'h0000; ins[1] = 16'h8000; ins[2] = 16'hFFFF;
`ifdef ADC_FIFO_SIGNED_EN
        outs[0] = 16'h8000; outs[1] = 16'h0000; outs[2] = 16'h7FFF;
`else
        outs[0] = 16'h0000; outs[1] = 16'h8000; outs[2] = 16'hFFFF;
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_data = ins[i]; in_valid = 1'b1; sb.push_back(outs[i]); tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            if (out_valid) begin
                exp_d = sb.pop_front();
                n_checks++;
                if (out_data !== exp_d) begin
                    n_fail++; $display("FAIL signed_conv: got %h want %h", out_data, exp_d);
                end
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL signed_drain_end: left=%0d want 0", sb.size());
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_clear_saturate();
        test_stream_wrap();
        test_signed();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
